// File: rtl/rv_defines_pkg.sv
// Shared RV32 core definitions: M-extension op encoding, muldiv FSM states,
// request bundle and the result finishing helper.
package rv_defines;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    md_op_e     op;
    logic       div;
    logic       neg;
    logic [4:0] rd;
  } md_req_t;

  localparam logic [4:0] MD_LAST_CNT = 5'd31;

  // Apply the latched result sign and pick the requested word.
  // Multiply: acc = 64-bit product. Divide: acc = {rem, quo}.
  function automatic logic [31:0] md_finish(
    input md_op_e      op,
    input logic        neg,
    input logic [63:0] acc
  );
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] res;
    p = neg ? -acc : acc;
    q = neg ? -acc[31:0] : acc[31:0];
    r = neg ? -acc[63:32] : acc[63:32];
    unique case (op)
      MD_MUL:                       res = p[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res = p[63:32];
      MD_DIV, MD_DIVU:              res = q;
      default:                      res = r;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide step.
// Ports: div selects divide, acc is the 64-bit working value, opb the operand.
import rv_defines::*;

module rv_muldiv_step (
  input  logic        div,
  input  logic [63:0] acc,
  input  logic [31:0] opb,
  output logic [63:0] acc_nxt
);

  logic [32:0] sum;
  logic [32:0] diff;

  // Multiply: acc = {partial, multiplier}; add on lsb then shift right.
  assign sum = {1'b0, acc[63:32]}
             + (acc[0] ? {1'b0, opb} : 33'd0);

  // Divide: acc = {rem, quo}; shift left, trial subtract at 33 bits.
  assign diff = acc[63:31] - {1'b0, opb};

  always_comb begin
    acc_nxt = '0;
    if (!div) begin
      acc_nxt = {sum, acc[31:1]};
    end else if (!diff[32]) begin
      acc_nxt = {diff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_nxt = {acc[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/rv_muldiv.sv
// RV32M multiply/divide unit for the alu2 stage, 32-cycle iterative.
// Ports: i_start/i_op/i_op1/i_op2/i_rd in; o_ready, o_valid, o_result, o_rd out.
import rv_defines::*;

module rv_muldiv (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic [4:0]  i_rd,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd
);

  md_state_e   state_q;
  md_state_e   state_d;
  logic [4:0]  cnt_q;
  logic [4:0]  cnt_d;
  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [63:0] acc_step;
  logic [31:0] opb_q;
  logic [31:0] opb_d;
  md_req_t     req_q;
  md_req_t     req_d;
  logic [31:0] res_q;
  logic [31:0] res_d;

  md_op_e      op_in;
  logic        s1;
  logic        s2;
  logic [31:0] m1;
  logic [31:0] m2;
  logic        is_div;
  logic        neg_in;
  logic        div0;
  logic        ovf;
  logic [31:0] fast_res;
  logic        accept;
  logic        calc_run;
  logic        done_end;

  assign op_in  = md_op_e'(i_op);
  assign is_div = i_op[2];

  assign s1 = i_op1[31] & (op_in == MD_MULH
                        || op_in == MD_MULHSU
                        || op_in == MD_DIV
                        || op_in == MD_REM);
  assign s2 = i_op2[31] & (op_in == MD_MULH
                        || op_in == MD_DIV
                        || op_in == MD_REM);

  assign m1 = s1 ? -i_op1 : i_op1;
  assign m2 = s2 ? -i_op2 : i_op2;

  // Remainder takes the dividend sign only.
  assign neg_in = (op_in == MD_REM) ? s1 : (s1 ^ s2);

  assign div0 = is_div & (i_op2 == 32'd0);
  assign ovf  = (op_in == MD_DIV || op_in == MD_REM)
              & (i_op1 == 32'h8000_0000)
              & (i_op2 == 32'hFFFF_FFFF);

  // i_op[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    fast_res = '0;
    if (div0) begin
      fast_res = i_op[1] ? i_op1 : 32'hFFFF_FFFF;
    end else begin
      fast_res = i_op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  assign o_ready  = (state_q != MD_CALC);
  assign accept   = i_start & o_ready & ~i_flush;
  assign calc_run = ~i_flush & (state_q == MD_CALC);
  assign done_end = ~i_flush & ~accept
                  & (state_q == MD_DONE);

  assign o_valid  = (state_q == MD_DONE) & ~i_flush;
  assign o_result = res_q;
  assign o_rd     = req_q.rd;

  rv_muldiv_step u_step (
    .div     (req_q.div),
    .acc     (acc_q),
    .opb     (opb_q),
    .acc_nxt (acc_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    req_d   = req_q;
    res_d   = res_q;
    unique case (1'b1)
      i_flush: begin
        state_d = MD_IDLE;
        cnt_d   = 5'd0;
      end
      accept: begin
        req_d.op  = op_in;
        req_d.div = is_div;
        req_d.neg = neg_in;
        req_d.rd  = i_rd;
        opb_d     = m2;
        acc_d     = {32'd0, m1};
        if (div0 || ovf) begin
          state_d = MD_DONE;
          cnt_d   = 5'd0;
          res_d   = fast_res;
        end else begin
          state_d = MD_CALC;
          cnt_d   = MD_LAST_CNT;
        end
      end
      calc_run: begin
        acc_d = acc_step;
        if (cnt_q == 5'd0) begin
          state_d = MD_DONE;
          res_d   = md_finish(req_q.op,
                              req_q.neg,
                              acc_step);
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      done_end: begin
        state_d = MD_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      req_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      req_q   <= req_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_rv_muldiv.sv
// Self-checking bench for rv_muldiv: directed table, corner sequences,
// and random ops against a plain-arithmetic reference model.
module tb_rv_muldiv;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_flush;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic [4:0]  i_rd;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rd;

  int checks;
  int errors;

  rv_muldiv dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_flush   (i_flush),
    .i_start   (i_start),
    .i_op      (i_op),
    .i_op1     (i_op1),
    .i_op2     (i_op2),
    .i_rd      (i_rd),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_result  (o_result),
    .o_rd      (o_rd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0]  op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6)
        && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Issue one op for a single cycle; leaves the bench #1 after the
  // accepting edge (cycle N+1).
  task automatic start_only(input logic [2:0]  op,
                            input logic [31:0] a,
                            input logic [31:0] b,
                            input logic [4:0]  rd);
    @(negedge i_clk);
    i_start = 1'b1;
    i_op    = op;
    i_op1   = a;
    i_op2   = b;
    i_rd    = rd;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  // Run an op and return result, rd and the cycle offset of o_valid
  // (0 if none within the bound). rdy_bad flags o_ready=1 before valid.
  task automatic do_op(input  logic [2:0]  op,
                       input  logic [31:0] a,
                       input  logic [31:0] b,
                       input  logic [4:0]  rd,
                       output logic [31:0] res,
                       output logic [4:0]  rdo,
                       output int          lat,
                       output int          rdy_bad);
    start_only(op, a, b, rd);
    lat     = 0;
    rdy_bad = 0;
    res     = '0;
    rdo     = '0;
    for (int k = 1; k <= 40; k++) begin
      if (o_valid) begin
        lat = k;
        res = o_result;
        rdo = o_rd;
        break;
      end
      if (o_ready) rdy_bad++;
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic watch_quiet(input string name, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
      if (o_valid) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    int          rbad;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;

    checks    = 0;
    errors    = 0;
    i_reset_n = 1'b0;
    i_flush   = 1'b0;
    i_start   = 1'b0;
    i_op      = '0;
    i_op1     = '0;
    i_op2     = '0;
    i_rd      = '0;

    tbl[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    tbl[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'd4, 32'd100, 32'd7, 32'd14, 33};
    tbl[5]  = '{3'd6, 32'd100, 32'd7, 32'd2, 33};
    tbl[6]  = '{3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33};
    tbl[7]  = '{3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33};
    tbl[8]  = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
    tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[11] = '{3'd7, 32'd9, 32'd0, 32'd9, 1};

    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result, 0);
    chk("rst_rd", o_rd, 0);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Directed table, issued back to back
    for (int i = 0; i < 12; i++) begin
      rd = 5'(i + 1);
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, rd,
            res, rdo, lat, rbad);
      chk($sformatf("tbl%0d_result", i), res, tbl[i].exp);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_rd", i), rdo, rd);
      if (tbl[i].lat == 33)
        chk($sformatf("tbl%0d_ready_low", i), rbad, 0);
    end

    // Flush in CALC at N+10
    repeat (3) @(posedge i_clk);
    start_only(3'd0, 32'd123, 32'd456, 5'd3);
    repeat (9) begin
      @(posedge i_clk);
      #1;
    end
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    chk("flush_ready", o_ready, 1);
    chk("flush_valid", o_valid, 0);
    i_flush = 1'b0;
    watch_quiet("flush_no_valid", 40);

    // Start together with flush is ignored
    @(negedge i_clk);
    i_start = 1'b1;
    i_flush = 1'b1;
    i_op    = 3'd4;
    i_op1   = 32'd50;
    i_op2   = 32'd5;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_flush = 1'b0;
    chk("start_flush_ready", o_ready, 1);
    watch_quiet("start_flush_no_valid", 40);

    // Reset mid-DIV at N+5
    start_only(3'd4, 32'd1000, 32'd3, 5'd9);
    repeat (4) begin
      @(posedge i_clk);
      #1;
    end
    i_reset_n = 1'b0;
    #1;
    chk("midrst_ready", o_ready, 1);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_result", o_result, 0);
    chk("midrst_rd", o_rd, 0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    watch_quiet("midrst_no_valid", 40);

    // Back-to-back: second start issued in DONE
    do_op(3'd5, 32'd1000, 32'd10, 5'd4, res, rdo, lat, rbad);
    chk("b2b_first", res, 32'd100);
    do_op(3'd7, 32'd1000, 32'd7, 5'd5, res, rdo, lat, rbad);
    chk("b2b_second_latency", lat, 33);
    chk("b2b_second_result", res, 32'd6);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      rd = 5'($urandom_range(0, 31));
      do_op(op, a, b, rd, res, rdo, lat, rbad);
      chk($sformatf("rnd%0d_op%0d_result", i, op),
          res, ref_md(op, a, b));
      chk($sformatf("rnd%0d_latency", i),
          lat, ref_lat(op, a, b));
      chk($sformatf("rnd%0d_rd", i), rdo, rd);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(posedge i_clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_muldiv.md
RV_MULDIV -- requirements
Module: rv_muldiv

Interface
REQ-001 SHALL have i_clk  input  1  core clock; all state changes on rising edge.
REQ-002 SHALL have i_reset_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have i_flush  input  1  pipeline flush from control (alu2 flush).
REQ-004 SHALL have i_start  input  1  M-extension op issued by the alu1 stage.
REQ-005 SHALL have i_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have i_op1, i_op2  input  32 each  rs1 and rs2 operand values (bypassed).
REQ-007 SHALL have i_rd  input  5  destination register.
REQ-008 SHALL have o_ready  output  1  unit can accept an op; drives control's alu2-ready input.
REQ-009 SHALL have o_valid  output  1  one-cycle result strobe.
REQ-010 SHALL have o_result  output  32  result, meaningful only while o_valid=1.
REQ-011 SHALL have o_rd  output  5  destination for o_result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL drive o_ready=1 in IDLE and DONE and o_ready=0 in CALC.
REQ-014 SHALL accept an op only when i_start=1, o_ready=1 and i_flush=0, latching i_op, operand magnitudes, result sign and i_rd.
REQ-015 SHALL, on accept at edge N, enter CALC at N+1, iterate exactly 32 cycles via a 5-bit down-counter 31..0, and enter DONE at N+33.
REQ-016 SHALL assert o_valid=1 only in DONE, with o_result and o_rd stable for that cycle.
REQ-017 SHALL leave DONE after one cycle: to CALC on a new accept, otherwise to IDLE (back-to-back ops allowed).
REQ-018 SHALL multiply as a radix-2 shift-add on unsigned magnitudes into a 64-bit product, negated at DONE if the sign is set.
REQ-019 SHALL treat operands as signed/signed for MULH, signed/unsigned for MULHSU and unsigned for MUL, MULHU, DIVU and REMU.
REQ-020 SHALL return product[31:0] for MUL and product[63:32] for MULH, MULHSU and MULHU.
REQ-021 SHALL divide by radix-2 restoring division on magnitudes; quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
REQ-022 SHALL, for divide by zero, skip CALC (IDLE/DONE -> DONE at N+1) and return 0xFFFFFFFF for DIV/DIVU and op1 for REM/REMU.
REQ-023 SHALL, for DIV/REM with op1=0x80000000 and op2=0xFFFFFFFF, skip CALC and return 0x80000000 (DIV) or 0 (REM) at N+1.
REQ-024 SHALL, on i_flush=1 in any state, go to IDLE next edge, suppress o_valid and ignore a simultaneous i_start.
REQ-025 SHALL compute all intermediate arithmetic at 33-bit width (restoring subtract) or 64-bit width (product) with no overflow loss.

Reset
REQ-026 SHALL, while i_reset_n=0, hold the FSM in IDLE, o_ready=1, o_valid=0, o_result=0, o_rd=0 and the counter=0.
REQ-027 SHALL abandon an in-flight op on reset assertion without producing o_valid after release.

Structure
REQ-028 SHALL place the muldiv op encoding enum and the FSM state enum in the shared rv_defines package.
REQ-029 SHALL contain one combinational sub-module rv_muldiv_step implementing a single shift-add or restore-subtract iteration.
REQ-030 SHALL be instantiated in the alu2 stage so that o_ready drives control's alu2-ready input.

Verification
REQ-031 SHALL cover: MUL op1=7, op2=0xFFFFFFFD accepted at N -> o_valid at N+33, o_result=0xFFFFFFEB, o_ready=0 for N+1..N+32.
REQ-032 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-033 SHALL cover: DIV 100/7 -> 14 and REM 100/7 -> 2; DIV -100/7 -> 0xFFFFFFF2 and REM -100/7 -> 0xFFFFFFFE; each at N+33.
REQ-034 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF and REM 0x80000000/0xFFFFFFFF -> 0, each with o_valid at N+1.
REQ-035 SHALL cover: i_flush at N+10 during CALC -> no o_valid, o_ready=1 from N+11; i_start together with i_flush -> not accepted.
REQ-036 SHALL cover: i_reset_n low at N+5 mid-DIV -> all outputs at reset values immediately, no o_valid after release; back-to-back start in DONE -> second o_valid exactly 33 cycles later.
